wbm_burst_gen: RTL and testbench
================================

# wbm_burst_gen

Parametrised, self-checking Wishbone B3 master traffic generator for the memory-controller bench and built-in self-test. It accepts single-command requests and issues classic, linear-incrementing or wrapping (4/8/16-beat) bursts with correct `cti_o`/`bte_o` sequencing. Write data comes from a deterministic address-based pattern, and read data is checked against the same pattern. A sticky `OK` flag and an error counter report the result.

## Interface
- `DW`, 32: data width in bits; multiple of 8, ≥8; `sel_o` width = DW/8.
- `AW`, 32: byte address width.
- `SEED`, {DW{1'b0}}: XOR mask applied to the data pattern.
- `TIMEOUT`, 255: ack watchdog limit in cycles; used only with `WBM_BURST_GEN_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_adr` in AW: start byte address, DW/8-aligned.
- `cmd_we` in 1: 1 = write, 0 = read/check.
- `cmd_burst` in 1: 0 = classic single, 1 = incrementing burst.
- `cmd_bte` in 2: 00 linear, 01 beat4, 10 beat8, 11 beat16.
- `cmd_len` in 4: linear burst length minus 1 (1..16 beats).
- `adr_o` out AW, `bte_o` out 2, `cti_o` out 3, `dat_o` out DW, `sel_o` out DW/8, `we_o` out 1, `cyc_o` out 1, `stb_o` out 1: Wishbone master outputs, all registered.
- `dat_i` in DW, `ack_i` in 1: Wishbone slave response.
- `done` out 1: one-cycle pulse when a command completes.
- `OK` out 1: sticky pass flag.
- `err_cnt` out 8: saturating count of read mismatches.
- `timeout` out 1: sticky watchdog flag.

## Operation
- Pattern: f(a) = zero-extend or truncate of (a >> log2(DW/8)) to DW, XOR `SEED`.
- FSM has two states, IDLE and BUS. `cmd_ready` = (state == IDLE).
- IDLE → BUS on `cmd_valid & cmd_ready`. The command fields are latched and the beat count is loaded:
  - classic: 1 beat; `cmd_len` and `cmd_bte` are ignored; `bte_o` = 00.
  - linear: `cmd_len`+1 beats.
  - beat4/8/16: 4, 8 or 16 beats.
- In BUS, `cyc_o`/`stb_o` stay high. `sel_o` is all ones. `dat_o` = f(`adr_o`) on writes and 0 on reads.
- `cti_o` values:
  - classic: 000 throughout.
  - burst: 010 on every beat except the last; 111 on the last beat. A 1-beat burst shows 111 only.
- A beat completes on `ack_i & stb_o`. On that edge, the address advances by DW/8 bytes:
  - linear: full-width increment, wrapping at 2^AW.
  - beatN: only address bits [log2(DW/8)+log2(N)-1 : log2(DW/8)] increment modulo N; upper bits are held.
- On the last beat's ack: `cyc_o`, `stb_o`, `we_o` and `cti_o` clear on that edge, `done` pulses on the next cycle, and the FSM returns to IDLE.
- Read check: on each acked read beat, compare `dat_i` with f(`adr_o`). On mismatch, `OK` ← 0 and `err_cnt` increments, saturating at 255.
- `ack_i` is ignored while `stb_o` = 0.
- `cmd_valid` is ignored while busy; no queueing.

## Timing
- Reset values:
  - `adr_o`, `dat_o`, `sel_o` = 0; `bte_o` = 00; `cti_o` = 000.
  - `we_o`, `cyc_o`, `stb_o`, `done`, `timeout` = 0; `err_cnt` = 0.
  - `OK` = 1; `cmd_ready` = 1.
- Reset mid-burst: all outputs take their reset values immediately; the burst is abandoned.
- Command accepted at edge T → `cyc_o`/`stb_o` high from T+1.
- With a zero-wait slave, an N-beat burst occupies cycles T+1..T+N, `cyc_o` is low at T+N+1, and `done` is high in cycle T+N+1.
- Next command acceptance is possible in cycle T+N+1, giving cyc high again at T+N+2. There is always at least one idle cycle between commands.
- Wait states: outputs hold until the ack.

## Configuration
- `WBM_BURST_GEN_TIMEOUT_EN` defined:
  - A counter clears on each ack and on command accept, and increments each BUS cycle without an ack.
  - On reaching `TIMEOUT`, on the next edge: `cyc_o`/`stb_o` clear, `timeout` ← 1 (sticky), `OK` ← 0, `done` pulses, and the FSM returns to IDLE.
- Undefined: BUS waits indefinitely for an ack; `timeout` is tied to 0; no counter logic exists.

## Test plan
- Write classic, `cmd_adr` = 0x10, DW = 32, SEED = 0, zero-wait slave → one beat: adr 0x10, dat 0x4, cti 000; `done` pulses at T+2.
- Write beat4 from 0x18 → addresses 0x18, 0x1C, 0x10, 0x14; cti 010, 010, 010, 111; bte 01.
- Linear burst, `cmd_len` = 15, from 0x0, 2 wait states per beat → 16 acks; address reaches 0x3C; cti 111 on beat 16 only; `OK` stays 1.
- Read beat8 from 0x0; memory model corrupts beat 3 (0x8 returns 0xFFFFFFFF) → `OK` = 0 and `err_cnt` = 1 after the burst; a second identical read gives `err_cnt` = 2.
- Assert `reset` during beat 2 of a beat16 burst → `cyc_o`/`stb_o` drop asynchronously, `OK` = 1, and a new command after release runs normally.
- With `WBM_BURST_GEN_TIMEOUT_EN` and TIMEOUT = 8, the slave never acks → `cyc_o` drops about 9 cycles after assertion; `timeout` = 1, `OK` = 0, `done` pulses once.

Source files
------------

// File: rtl/wbm_burst_gen.sv
// Wishbone B3 master traffic generator: classic, linear and wrapping bursts with a
// self-checking address-derived data pattern. Define WBM_BURST_GEN_TIMEOUT_EN for the ack watchdog.
module wbm_burst_gen #(
    parameter int unsigned   DW      = 32,
    parameter int unsigned   AW      = 32,
    parameter logic [DW-1:0] SEED    = {DW{1'b0}},
    parameter int            TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [AW-1:0]     cmd_adr,
    input  logic              cmd_we,
    input  logic              cmd_burst,
    input  logic [1:0]        cmd_bte,
    input  logic [3:0]        cmd_len,
    output logic [AW-1:0]     adr_o,
    output logic [1:0]        bte_o,
    output logic [2:0]        cti_o,
    output logic [DW-1:0]     dat_o,
    output logic [DW/8-1:0]   sel_o,
    output logic              we_o,
    output logic              cyc_o,
    output logic              stb_o,
    input  logic [DW-1:0]     dat_i,
    input  logic              ack_i,
    output logic              done,
    output logic              OK,
    output logic [7:0]        err_cnt,
    output logic              timeout
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned SH = $clog2(SW);

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    typedef enum logic {
        S_IDLE,
        S_BUS
    } state_t;

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        logic [AW-1:0] word;
        word = a >> SH;
        return DW'(word) ^ SEED;
    endfunction

    // Wrapping bursts only advance the beat-index field; everything above it is held.
    function automatic logic [AW-1:0] next_adr(input logic [AW-1:0] a, input logic [1:0] bte);
        logic [AW-1:0] inc;
        logic [AW-1:0] mask;
        inc = a + AW'(SW);
        case (bte)
            2'b01:   mask = AW'(3) << SH;
            2'b10:   mask = AW'(7) << SH;
            2'b11:   mask = AW'(15) << SH;
            default: mask = {AW{1'b1}};
        endcase
        return (a & ~mask) | (inc & mask);
    endfunction

    function automatic logic [4:0] beat_count(input logic burst, input logic [1:0] bte,
                                              input logic [3:0] len);
        logic [4:0] n;
        if (!burst) begin
            n = 5'd1;
        end else begin
            case (bte)
                2'b01:   n = 5'd4;
                2'b10:   n = 5'd8;
                2'b11:   n = 5'd16;
                default: n = {1'b0, len} + 5'd1;
            endcase
        end
        return n;
    endfunction

    state_t           state_q, state_d;
    logic [AW-1:0]    adr_q, adr_d;
    logic [1:0]       bte_q, bte_d;
    logic [2:0]       cti_q, cti_d;
    logic [DW-1:0]    dat_q, dat_d;
    logic [SW-1:0]    sel_q, sel_d;
    logic             we_q, we_d;
    logic             cyc_q, cyc_d;
    logic             stb_q, stb_d;
    logic [4:0]       beats_q, beats_d;
    logic             done_q, done_d;
    logic             ok_q, ok_d;
    logic [7:0]       err_q, err_d;
    logic             end_bus;

`ifdef WBM_BURST_GEN_TIMEOUT_EN
    localparam int unsigned       WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_q, timeout_d;
`endif

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        bte_d   = bte_q;
        cti_d   = cti_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        beats_d = beats_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        err_d   = err_q;
        end_bus = 1'b0;
`ifdef WBM_BURST_GEN_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_BUS;
                    adr_d   = cmd_adr;
                    bte_d   = cmd_burst ? cmd_bte : 2'b00;
                    beats_d = beat_count(cmd_burst, cmd_bte, cmd_len);
                    if (!cmd_burst)
                        cti_d = CTI_CLASSIC;
                    else if (beats_d == 5'd1)
                        cti_d = CTI_END;
                    else
                        cti_d = CTI_INCR;
                    dat_d   = cmd_we ? pattern(cmd_adr) : '0;
                    sel_d   = '1;
                    we_d    = cmd_we;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
`ifdef WBM_BURST_GEN_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end
            end

            S_BUS: begin
                if (stb_q && ack_i) begin
                    adr_d = next_adr(adr_q, bte_q);
                    dat_d = we_q ? pattern(adr_d) : '0;
                    if (!we_q && (dat_i != pattern(adr_q))) begin
                        ok_d = 1'b0;
                        if (err_q != 8'hFF)
                            err_d = err_q + 8'd1;
                    end
`ifdef WBM_BURST_GEN_TIMEOUT_EN
                    wd_d = '0;
`endif
                    if (beats_q == 5'd1) begin
                        end_bus = 1'b1;
                    end else begin
                        beats_d = beats_q - 5'd1;
                        cti_d   = (beats_q == 5'd2) ? CTI_END : CTI_INCR;
                    end
                end
`ifdef WBM_BURST_GEN_TIMEOUT_EN
                else if (wd_q == WD_LIMIT) begin
                    end_bus   = 1'b1;
                    timeout_d = 1'b1;
                    ok_d      = 1'b0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end

            default: state_d = S_IDLE;
        endcase

        // Leave a quiet bus behind once the command finishes or is abandoned.
        if (end_bus) begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            cti_d   = CTI_CLASSIC;
            sel_d   = '0;
            dat_d   = '0;
            done_d  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            bte_q   <= 2'b00;
            cti_q   <= CTI_CLASSIC;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            beats_q <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b1;
            err_q   <= '0;
`ifdef WBM_BURST_GEN_TIMEOUT_EN
            wd_q      <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            bte_q   <= bte_d;
            cti_q   <= cti_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            beats_q <= beats_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
`ifdef WBM_BURST_GEN_TIMEOUT_EN
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign adr_o     = adr_q;
    assign bte_o     = bte_q;
    assign cti_o     = cti_q;
    assign dat_o     = dat_q;
    assign sel_o     = sel_q;
    assign we_o      = we_q;
    assign cyc_o     = cyc_q;
    assign stb_o     = stb_q;
    assign done      = done_q;
    assign OK        = ok_q;
    assign err_cnt   = err_q;

`ifdef WBM_BURST_GEN_TIMEOUT_EN
    assign timeout = timeout_q;
`else
    // Without the watchdog the flag can never fire; a negative limit is the only way to read it as set.
    assign timeout = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_wbm_burst_gen.sv
// Directed bench for wbm_burst_gen: a scoreboard of expected beats is filled per command
// and drained by a Wishbone slave model that checks every acked beat.
module tb_wbm_burst_gen;

    localparam int          DW      = 32;
    localparam int          AW      = 32;
    localparam logic [31:0] SEED    = 32'h0;
    localparam int          TIMEOUT = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [AW-1:0]   cmd_adr;
    logic            cmd_we;
    logic            cmd_burst;
    logic [1:0]      cmd_bte;
    logic [3:0]      cmd_len;
    logic [AW-1:0]   adr_o;
    logic [1:0]      bte_o;
    logic [2:0]      cti_o;
    logic [DW-1:0]   dat_o;
    logic [DW/8-1:0] sel_o;
    logic            we_o;
    logic            cyc_o;
    logic            stb_o;
    logic [DW-1:0]   dat_i;
    logic            ack_i;
    logic            done;
    logic            OK;
    logic [7:0]      err_cnt;
    logic            timeout;

    wbm_burst_gen #(
        .DW(DW), .AW(AW), .SEED(SEED), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
        .cmd_we(cmd_we), .cmd_burst(cmd_burst), .cmd_bte(cmd_bte), .cmd_len(cmd_len),
        .adr_o(adr_o), .bte_o(bte_o), .cti_o(cti_o), .dat_o(dat_o), .sel_o(sel_o),
        .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o),
        .dat_i(dat_i), .ack_i(ack_i),
        .done(done), .OK(OK), .err_cnt(err_cnt), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic        we;
        logic [31:0] dat;
    } beat_t;

    beat_t       sb[$];
    int          chk_cnt     = 0;
    int          pass_cnt    = 0;
    int          wait_states = 0;
    int          wait_cnt    = 0;
    int          ack_cnt     = 0;
    bit          no_ack      = 1'b0;
    bit          corrupt_en  = 1'b0;
    logic [31:0] corrupt_adr = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return (a >> 2) ^ SEED;
    endfunction

    // Golden beat list: wrapping bursts stay inside an N*4-byte aligned window.
    function automatic void push_expected(input logic [31:0] adr, input logic we,
                                          input logic burst, input logic [1:0] bte,
                                          input logic [3:0] len);
        int          n;
        logic [31:0] span;
        beat_t       b;
        if (!burst)              n = 1;
        else if (bte == 2'b00)   n = int'(len) + 1;
        else                     n = 4 << (int'(bte) - 1);
        span = 32'(n * 4);
        for (int i = 0; i < n; i++) begin
            if (burst && bte != 2'b00)
                b.adr = (adr & ~(span - 32'd1)) | ((adr + 32'(i * 4)) % span);
            else
                b.adr = adr + 32'(i * 4);
            b.cti = !burst ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
            b.bte = burst ? bte : 2'b00;
            b.we  = we;
            b.dat = we ? pattern(b.adr) : 32'h0;
            sb.push_back(b);
        end
    endfunction

    // Slave model: responds at the falling edge so the DUT samples ack on the next rising edge.
    initial begin : slave
        beat_t b;
        ack_i = 1'b0;
        dat_i = '0;
        forever begin
            @(negedge clk);
            ack_i = 1'b0;
            if (!reset && cyc_o && stb_o && !no_ack) begin
                if (wait_cnt < wait_states) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    ack_i    = 1'b1;
                    ack_cnt++;
                    if (!we_o && corrupt_en && adr_o == corrupt_adr)
                        dat_i = 32'hFFFF_FFFF;
                    else
                        dat_i = pattern(adr_o);
                    check("beat_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        b = sb.pop_front();
                        check("beat_adr", adr_o, b.adr);
                        check("beat_cti", cti_o, b.cti);
                        check("beat_bte", bte_o, b.bte);
                        check("beat_we", we_o, b.we);
                        check("beat_sel", sel_o, 4'hF);
                        check("beat_dat", dat_o, b.dat);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] adr, input logic we, input logic burst,
                         input logic [1:0] bte, input logic [3:0] len, input bit expect_beats);
        if (expect_beats)
            push_expected(adr, we, burst, bte, len);
        @(negedge clk);
        cmd_adr   = adr;
        cmd_we    = we;
        cmd_burst = burst;
        cmd_bte   = bte;
        cmd_len   = len;
        cmd_valid = 1'b1;
        check("cmd_ready_idle", cmd_ready, 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Counts falling edges after the accept edge until done; optionally pokes cmd_valid while busy.
    task automatic wait_done(input int exp_k, input bit poke);
        int k = 0;
        bit got = 1'b0;
        while (!got && k < 3000) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check("cyc_after_accept", cyc_o, 1);
                check("busy_not_ready", cmd_ready, 0);
            end
            if (poke && k == 2) begin
                cmd_adr   = 32'h0000_0F00;
                cmd_we    = 1'b1;
                cmd_burst = 1'b0;
                cmd_valid = 1'b1;
            end
            if (poke && k == 3)
                cmd_valid = 1'b0;
            if (done)
                got = 1'b1;
        end
        check("done_seen", got, 1);
        check("done_cycle", k, exp_k);
        check("cyc_low_at_done", cyc_o, 0);
        check("ready_at_done", cmd_ready, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: simulation did not finish within 200000 time units");
        $fatal(1);
    end

    initial begin : main
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_adr   = '0;
        cmd_we    = 1'b0;
        cmd_burst = 1'b0;
        cmd_bte   = 2'b00;
        cmd_len   = 4'h0;
        #1;
        check("rst_adr", adr_o, 0);
        check("rst_dat", dat_o, 0);
        check("rst_sel", sel_o, 0);
        check("rst_bte", bte_o, 0);
        check("rst_cti", cti_o, 0);
        check("rst_we", we_o, 0);
        check("rst_cyc", cyc_o, 0);
        check("rst_stb", stb_o, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err", err_cnt, 0);
        check("rst_ok", OK, 1);
        check("rst_ready", cmd_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Classic write; bte/len fields must be ignored.
        issue(32'h10, 1'b1, 1'b0, 2'b11, 4'hF, 1'b1);
        wait_done(2, 1'b0);

        // Wrapping 4-beat write crossing the window boundary.
        issue(32'h18, 1'b1, 1'b1, 2'b01, 4'h0, 1'b1);
        wait_done(5, 1'b0);

        // 16-beat linear write with two wait states; a command poked while busy is dropped.
        wait_states = 2;
        ack_cnt     = 0;
        issue(32'h0, 1'b1, 1'b1, 2'b00, 4'hF, 1'b1);
        wait_done(49, 1'b1);
        wait_states = 0;
        check("linear16_acks", ack_cnt, 16);
        check("linear16_ok", OK, 1);

        // One-beat burst shows end-of-burst only; linear address wraps at 2^AW.
        issue(32'h80, 1'b1, 1'b1, 2'b00, 4'h0, 1'b1);
        wait_done(2, 1'b0);
        issue(32'hFFFF_FFFC, 1'b1, 1'b1, 2'b00, 4'h1, 1'b1);
        wait_done(3, 1'b0);

        // Clean linear read.
        issue(32'h100, 1'b0, 1'b1, 2'b00, 4'h3, 1'b1);
        wait_done(5, 1'b0);
        check("clean_read_ok", OK, 1);
        check("clean_read_err", err_cnt, 0);

        // Wrapping 8-beat reads with one corrupted word each.
        corrupt_en  = 1'b1;
        corrupt_adr = 32'h8;
        issue(32'h0, 1'b0, 1'b1, 2'b10, 4'h0, 1'b1);
        wait_done(9, 1'b0);
        check("bad_read1_ok", OK, 0);
        check("bad_read1_err", err_cnt, 1);
        issue(32'h0, 1'b0, 1'b1, 2'b10, 4'h0, 1'b1);
        wait_done(9, 1'b0);
        check("bad_read2_ok", OK, 0);
        check("bad_read2_err", err_cnt, 2);
        corrupt_en = 1'b0;

        // Reset during beat 2 of a 16-beat wrapping write.
        issue(32'h20, 1'b1, 1'b1, 2'b11, 4'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_cyc", cyc_o, 0);
        check("midrst_stb", stb_o, 0);
        check("midrst_ok", OK, 1);
        check("midrst_err", err_cnt, 0);
        check("midrst_cti", cti_o, 0);
        check("midrst_ready", cmd_ready, 1);
        sb.delete();
        wait_cnt = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(32'h34, 1'b1, 1'b1, 2'b11, 4'h0, 1'b1);
        wait_done(17, 1'b0);
        check("post_rst_ok", OK, 1);

`ifdef WBM_BURST_GEN_TIMEOUT_EN
        begin
            int drop_k   = 0;
            int done_cnt = 0;
            no_ack = 1'b1;
            issue(32'h40, 1'b1, 1'b0, 2'b00, 4'h0, 1'b0);
            for (int k = 1; k <= 14; k++) begin
                @(negedge clk);
                if (!cyc_o && drop_k == 0)
                    drop_k = k;
                if (done)
                    done_cnt++;
            end
            check("wd_drop_cycle", drop_k, 10);
            check("wd_done_pulses", done_cnt, 1);
            check("wd_timeout", timeout, 1);
            check("wd_ok", OK, 0);
            check("wd_ready", cmd_ready, 1);
            no_ack = 1'b0;
        end
`else
        check("no_wd_timeout", timeout, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
